// File: rtl/xor_param_loader_if.sv
// Parameter-word stream into the loader: data, valid, start-of-frame, and ready coming back.
interface xor_param_loader_if #(
  parameter int DATA_WIDTH = 12
);
  logic [DATA_WIDTH-1:0] s_data;
  logic                  s_valid;
  logic                  s_sof;
  logic                  s_ready;

  modport master (
    output s_data,
    output s_valid,
    output s_sof,
    input  s_ready
  );

  modport slave (
    input  s_data,
    input  s_valid,
    input  s_sof,
    output s_ready
  );
endinterface

// File: rtl/xor_param_loader.sv
// Streams bias/weight words into a shadow bank and commits the whole set to the active bank
// in one cycle, so the neurons only ever see a complete parameter set.
module xor_param_loader #(
  parameter int NUM_NEURONS    = 3,
  parameter int NUM_INPUTS     = 2,
  parameter int TIMEOUT_CYCLES = 255,
  parameter int DATA_WIDTH     = 12
) (
  input  logic                                       clk,
  input  logic                                       rst,
  xor_param_loader_if.slave                          s,
  output logic [NUM_NEURONS*DATA_WIDTH-1:0]            bias_out,
  output logic [NUM_NEURONS*NUM_INPUTS*DATA_WIDTH-1:0] weight_out,
  output logic                                       params_valid,
  output logic                                       param_update,
  output logic                                       load_busy,
  output logic                                       load_err
);

  localparam int SLOTS = NUM_INPUTS + 1;
  localparam int WORDS = NUM_NEURONS * SLOTS;
  localparam int LAST  = WORDS - 1;
  localparam int CNT_W = $clog2(WORDS + 1);
  // A disabled timeout still needs a 1-bit counter so the declaration stays legal.
  localparam int TMO_W = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
  localparam int TMO_LIMIT = (TIMEOUT_CYCLES > 0) ? TIMEOUT_CYCLES - 1 : 0;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    LOAD   = 2'd1,
    COMMIT = 2'd2
  } state_t;

  state_t                 state_reg;
  logic [CNT_W-1:0]       cnt_reg;
  logic [TMO_W-1:0]       tmo_reg;
  logic                   s_ready_reg;
  logic                   params_valid_reg;
  logic                   param_update_reg;
  logic                   load_busy_reg;
  logic                   load_err_reg;
  logic [DATA_WIDTH-1:0]  shadow_reg [WORDS];
  logic [DATA_WIDTH-1:0]  active_reg [WORDS];
  logic                   xfer;

  assign xfer      = s.s_valid & s_ready_reg;
  assign s.s_ready = s_ready_reg;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_reg        <= IDLE;
      cnt_reg          <= '0;
      tmo_reg          <= '0;
      s_ready_reg      <= 1'b0;
      params_valid_reg <= 1'b0;
      param_update_reg <= 1'b0;
      load_busy_reg    <= 1'b0;
      load_err_reg     <= 1'b0;
      for (int k = 0; k < WORDS; k++) begin
        shadow_reg[k] <= '0;
        active_reg[k] <= '0;
      end
    end else begin
      param_update_reg <= 1'b0;
      load_err_reg     <= 1'b0;
      case (state_reg)
        IDLE: begin
          s_ready_reg <= 1'b1;
          tmo_reg     <= '0;
          if (xfer) begin
            if (s.s_sof) begin
              shadow_reg[0] <= s.s_data;
              load_busy_reg <= 1'b1;
              if (WORDS == 1) begin
                state_reg   <= COMMIT;
                s_ready_reg <= 1'b0;
              end else begin
                state_reg <= LOAD;
                cnt_reg   <= CNT_W'(1);
              end
            end else begin
              load_err_reg <= 1'b1;
            end
          end
        end

        LOAD: begin
          if (xfer) begin
            tmo_reg <= '0;
            if (s.s_sof) begin
              // A fresh start-of-frame abandons the partial frame and restarts it.
              load_err_reg  <= 1'b1;
              shadow_reg[0] <= s.s_data;
              cnt_reg       <= CNT_W'(1);
            end else begin
              shadow_reg[cnt_reg] <= s.s_data;
              cnt_reg             <= cnt_reg + CNT_W'(1);
              if (cnt_reg == CNT_W'(LAST)) begin
                state_reg   <= COMMIT;
                s_ready_reg <= 1'b0;
              end
            end
          end else if ((TIMEOUT_CYCLES != 0) && (tmo_reg == TMO_W'(TMO_LIMIT))) begin
            load_err_reg  <= 1'b1;
            state_reg     <= IDLE;
            load_busy_reg <= 1'b0;
            cnt_reg       <= '0;
            tmo_reg       <= '0;
          end else if (tmo_reg != {TMO_W{1'b1}}) begin
            tmo_reg <= tmo_reg + TMO_W'(1);
          end
        end

        COMMIT: begin
          for (int k = 0; k < WORDS; k++) begin
            active_reg[k] <= shadow_reg[k];
          end
          params_valid_reg <= 1'b1;
          param_update_reg <= 1'b1;
          cnt_reg          <= '0;
          tmo_reg          <= '0;
          state_reg        <= IDLE;
          load_busy_reg    <= 1'b0;
          s_ready_reg      <= 1'b1;
        end

        default: begin
          state_reg     <= IDLE;
          load_busy_reg <= 1'b0;
          cnt_reg       <= '0;
          tmo_reg       <= '0;
        end
      endcase
    end
  end

  // Word k of a frame belongs to neuron k/SLOTS; slot 0 is the bias, slots 1.. are weights.
  genvar gi, gj;
  generate
    for (gi = 0; gi < NUM_NEURONS; gi++) begin : g_neuron
      assign bias_out[gi*DATA_WIDTH +: DATA_WIDTH] = active_reg[gi*SLOTS];
      for (gj = 0; gj < NUM_INPUTS; gj++) begin : g_input
        assign weight_out[(gi*NUM_INPUTS+gj)*DATA_WIDTH +: DATA_WIDTH] =
          active_reg[gi*SLOTS+1+gj];
      end
    end
  endgenerate

  assign params_valid = params_valid_reg;
  assign param_update = param_update_reg;
  assign load_busy    = load_busy_reg;
  assign load_err     = load_err_reg;

endmodule

// File: tb/tb_xor_param_loader.sv
// Directed bench for xor_param_loader: table of frames plus hand-written error, timeout and
// reset sequences. Two instances: default timeout, and an 8-cycle timeout for the stall case.
module tb_xor_param_loader;
  localparam int DW = 12;
  localparam int NN = 3;
  localparam int NI = 2;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst;
  logic          sel;
  logic [DW-1:0] d;
  logic          v;
  logic          sof;

  xor_param_loader_if #(.DATA_WIDTH(DW)) ifa ();
  xor_param_loader_if #(.DATA_WIDTH(DW)) ifb ();

  assign ifa.s_data  = d;
  assign ifa.s_valid = v & ~sel;
  assign ifa.s_sof   = sof;
  assign ifb.s_data  = d;
  assign ifb.s_valid = v & sel;
  assign ifb.s_sof   = sof;

  logic [NN*DW-1:0]    ba, bb;
  logic [NN*NI*DW-1:0] wa, wb;
  logic pva, pua, bza, ea, pvb, pub, bzb, eb;

  xor_param_loader #(.NUM_NEURONS(NN), .NUM_INPUTS(NI), .TIMEOUT_CYCLES(255), .DATA_WIDTH(DW))
  dut_a (
    .clk(clk), .rst(rst), .s(ifa), .bias_out(ba), .weight_out(wa),
    .params_valid(pva), .param_update(pua), .load_busy(bza), .load_err(ea)
  );

  xor_param_loader #(.NUM_NEURONS(NN), .NUM_INPUTS(NI), .TIMEOUT_CYCLES(8), .DATA_WIDTH(DW))
  dut_b (
    .clk(clk), .rst(rst), .s(ifb), .bias_out(bb), .weight_out(wb),
    .params_valid(pvb), .param_update(pub), .load_busy(bzb), .load_err(eb)
  );

  logic                ready, pv, pu, busy, err;
  logic [NN*DW-1:0]    bias;
  logic [NN*NI*DW-1:0] weight;
  assign ready  = sel ? ifb.s_ready : ifa.s_ready;
  assign bias   = sel ? bb : ba;
  assign weight = sel ? wb : wa;
  assign pv     = sel ? pvb : pva;
  assign pu     = sel ? pub : pua;
  assign busy   = sel ? bzb : bza;
  assign err    = sel ? eb : ea;

  int checks = 0;
  int errors = 0;
  int err_seen = 0;
  int pu_seen = 0;

  always @(negedge clk) begin
    if (err) err_seen++;
    if (pu)  pu_seen++;
  end

  typedef struct {
    logic [9*DW-1:0]     words;
    int                  gap;
    logic [NN*DW-1:0]    exp_b;
    logic [NN*NI*DW-1:0] exp_w;
  } vec_t;

  // Frame images: word k at [k*12 +: 12]; expected outputs worked out by hand.
  localparam logic [107:0] F1_W = 108'hC00_200_000_200_200_E00_200_200_000;
  localparam logic [35:0]  F1_B = 36'h000_E00_000;
  localparam logic [71:0]  F1_X = 72'hC00_200_200_200_200_200;
  localparam logic [107:0] F2_W = 108'h456_FFF_ABC_123_800_7FF_003_002_001;
  localparam logic [35:0]  F2_B = 36'hABC_7FF_001;
  localparam logic [71:0]  F2_X = 72'h456_FFF_123_800_003_002;
  localparam logic [107:0] F3_W = 108'h129_118_107_0F6_0E5_0D4_0C3_0B2_0A1;
  localparam logic [35:0]  F3_B = 36'h107_0D4_0A1;
  localparam logic [71:0]  F3_X = 72'h129_118_0F6_0E5_0C3_0B2;

  task automatic chk(input string nm, input logic [71:0] act, input logic [71:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h", nm, act, exp);
    end
  endtask

  // Called at a negedge; returns at the negedge following the accepting edge.
  task automatic send(input logic [DW-1:0] w, input logic f);
    int n;
    d = w; sof = f; v = 1'b1; n = 0;
    while (!ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (!ready) begin
      checks++;
      errors++;
      $display("FAIL send_ready_wait actual=%b expected=1", ready);
    end
    @(negedge clk);
    $display("xfer dut=%0d data=%h sof=%b t=%0t", sel, w, f, $time);
    v = 1'b0; sof = 1'b0;
  endtask

  task automatic send_words(input logic [107:0] words, input int first, input int last,
                            input int gap);
    for (int k = first; k <= last; k++) begin
      if (k > first) repeat (gap) @(negedge clk);
      send(words[k*DW +: DW], (k == 0));
    end
  endtask

  task automatic commit_check(input string nm, input logic [35:0] eb_, input logic [71:0] ew,
                              input logic [35:0] old_b);
    chk({nm, "_held_bias"}, 72'(bias), 72'(old_b));
    chk({nm, "_commit_ready"}, 72'(ready), 72'd0);
    chk({nm, "_commit_busy"}, 72'(busy), 72'd1);
    chk({nm, "_pu_early"}, 72'(pu), 72'd0);
    @(negedge clk);
    chk({nm, "_pu"}, 72'(pu), 72'd1);
    chk({nm, "_bias"}, 72'(bias), 72'(eb_));
    chk({nm, "_weight"}, weight, ew);
    chk({nm, "_valid"}, 72'(pv), 72'd1);
    chk({nm, "_busy_idle"}, 72'(busy), 72'd0);
    chk({nm, "_ready_back"}, 72'(ready), 72'd1);
    @(negedge clk);
    chk({nm, "_pu_end"}, 72'(pu), 72'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog actual=running expected=finished");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t tbl [4];
    logic [35:0] old_b;
    int e0, p0;

    tbl[0] = '{words: F1_W, gap: 0,  exp_b: F1_B, exp_w: F1_X};
    tbl[1] = '{words: F2_W, gap: 3,  exp_b: F2_B, exp_w: F2_X};
    tbl[2] = '{words: F3_W, gap: 1,  exp_b: F3_B, exp_w: F3_X};
    tbl[3] = '{words: F1_W, gap: 10, exp_b: F1_B, exp_w: F1_X};

    rst = 1'b0; sel = 1'b0; d = '0; v = 1'b0; sof = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_bias", 72'(ba), 72'd0);
    chk("rst_weight", wa, 72'd0);
    chk("rst_valid", 72'(pva), 72'd0);
    chk("rst_update", 72'(pua), 72'd0);
    chk("rst_busy", 72'(bza), 72'd0);
    chk("rst_err", 72'(ea), 72'd0);
    chk("rst_ready", 72'(ifa.s_ready), 72'd0);
    rst = 1'b1;
    chk("release_ready", 72'(ifa.s_ready), 72'd0);
    @(negedge clk);
    chk("first_edge_ready", 72'(ifa.s_ready), 72'd1);

    // Clean frames, with and without inter-word gaps.
    old_b = '0;
    e0 = err_seen;
    p0 = pu_seen;
    for (int i = 0; i < 4; i++) begin
      send_words(tbl[i].words, 0, 8, tbl[i].gap);
      commit_check($sformatf("frame%0d", i), tbl[i].exp_b, tbl[i].exp_w, old_b);
      old_b = tbl[i].exp_b;
    end
    chk("frames_no_err", 72'(err_seen - e0), 72'd0);
    chk("frames_pu_count", 72'(pu_seen - p0), 72'd4);

    // Stray word in IDLE.
    e0 = err_seen;
    send(12'h555, 1'b0);
    chk("stray_err", 72'(err), 72'd1);
    @(negedge clk);
    chk("stray_err_end", 72'(err), 72'd0);
    chk("stray_ready", 72'(ready), 72'd1);
    chk("stray_bias", 72'(bias), 72'(F1_B));
    chk("stray_weight", weight, F1_X);
    chk("stray_valid", 72'(pv), 72'd1);
    chk("stray_err_count", 72'(err_seen - e0), 72'd1);

    // Start-of-frame reasserted at word 5 restarts the frame.
    e0 = err_seen;
    send_words(F2_W, 0, 4, 0);
    send(F3_W[0 +: DW], 1'b1);
    chk("restart_err", 72'(err), 72'd1);
    chk("restart_bias_held", 72'(bias), 72'(F1_B));
    send_words(F3_W, 1, 8, 0);
    commit_check("restart", F3_B, F3_X, F1_B);
    chk("restart_err_count", 72'(err_seen - e0), 72'd1);

    // Timeout instance: commit a frame, then stall after word 3.
    sel = 1'b1;
    @(negedge clk);
    send_words(F1_W, 0, 8, 0);
    commit_check("tmo_base", F1_B, F1_X, 36'd0);
    send_words(F2_W, 0, 2, 0);
    repeat (7) @(negedge clk);
    chk("tmo_not_yet_err", 72'(err), 72'd0);
    chk("tmo_not_yet_busy", 72'(busy), 72'd1);
    @(negedge clk);
    chk("tmo_err", 72'(err), 72'd1);
    chk("tmo_idle", 72'(busy), 72'd0);
    chk("tmo_bias", 72'(bias), 72'(F1_B));
    chk("tmo_weight", weight, F1_X);
    chk("tmo_valid", 72'(pv), 72'd1);
    @(negedge clk);
    chk("tmo_err_end", 72'(err), 72'd0);
    send_words(F2_W, 0, 8, 0);
    commit_check("tmo_next", F2_B, F2_X, F1_B);

    // Reset in the middle of a frame after a committed one.
    sel = 1'b0;
    @(negedge clk);
    send_words(F2_W, 0, 3, 0);
    #2 rst = 1'b0;
    #1;
    chk("arst_bias", 72'(ba), 72'd0);
    chk("arst_weight", wa, 72'd0);
    chk("arst_valid", 72'(pva), 72'd0);
    chk("arst_busy", 72'(bza), 72'd0);
    chk("arst_ready", 72'(ifa.s_ready), 72'd0);
    chk("arst_b_bias", 72'(bb), 72'd0);
    @(negedge clk);
    rst = 1'b1;
    chk("arst_release_ready", 72'(ifa.s_ready), 72'd0);
    @(negedge clk);
    chk("arst_first_edge_ready", 72'(ifa.s_ready), 72'd1);
    chk("arst_valid_after", 72'(pva), 72'd0);
    send_words(F2_W, 0, 8, 0);
    commit_check("after_rst", F2_B, F2_X, 36'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
